mem_access_ctrl: RTL and testbench
==================================

// Module: mem_access_ctrl
// PURPOSE
//  MEM-stage data-memory access controller; consumes the EXE->MEM pipeline register outputs.
//  Issues load/store requests on the split addr_ok/data_ok data bus and holds the pipeline until each access completes.
//  Aligns and extends load data, then registers the MEM->WB result.
//  Sits between the EXE->MEM register and the WB stage.
// PARAMETERS
//  STAT_W  16  width of saturating stall-cycle performance counter
// PORTS
//  clk             in   1   clock, rising edge
//  rst             in   1   reset; asynchronous, active-high
//  MEM_Flush       in   1   flush instruction in MEM (exception/redirect)
//  WB_Wr           in   1   WB stage can accept (downstream not stalled)
//  WB_Flush        in   1   clear WB register
//  MEM_ALUOut      in   32  effective address / ALU result
//  MEM_OutB        in   32  store data (rt)
//  MEM_PC          in   32  PC of instruction in MEM
//  MEM_Dst         in   5   destination register
//  MEM_RegsWr      in   1   instruction writes a GPR
//  MEM_IsLoad      in   1   load
//  MEM_IsStore     in   1   store
//  MEM_Size        in   2   0=byte 1=half 2=word (3 reserved, treated as word)
//  MEM_LoadSign    in   1   1=sign-extend, 0=zero-extend
//  MEM_ExcValid    in   1   exception already flagged; suppresses access
//  data_req        out  1   request valid
//  data_wr         out  1   1=store
//  data_size       out  2   = MEM_Size
//  data_addr       out  32  = MEM_ALUOut
//  data_wstrb      out  4   byte enables
//  data_wdata      out  32  store data replicated per lane
//  data_addr_ok    in   1   request accepted
//  data_data_ok    in   1   response valid (rdata for loads, write ack for stores)
//  data_rdata      in   32  load data
//  MEM_MemStall    out  1   hold IF..MEM (combinational)
//  WB_Result       out  32  result to write back
//  WB_Dst          out  5   WB destination
//  WB_RegsWr       out  1   WB write enable
//  WB_PC           out  32  WB PC
//  perf_stall_cnt  out  STAT_W  cycles with MEM_MemStall=1, saturating
// BEHAVIOUR
//  pending = (MEM_IsLoad|MEM_IsStore) & ~MEM_ExcValid & ~MEM_Flush. Reset: state=IDLE, all outputs/registers 0.
//  FSM states IDLE, WAIT, DONE, DRAIN.
//   IDLE:  data_req = pending. req&addr_ok -> WAIT. Req is held stable until addr_ok.
//   WAIT:  data_ok & MEM_Flush -> IDLE (response discarded). MEM_Flush alone -> DRAIN.
//          data_ok & advance -> IDLE. data_ok & ~advance -> DONE; aligned load data is latched.
//   DONE:  advance or MEM_Flush -> IDLE. No new request is issued for the held instruction.
//   DRAIN: data_req=0; data_ok -> IDLE (data dropped). A new request may issue in the cycle after.
//  MEM_MemStall = (IDLE & pending) | (WAIT & ~data_ok) | (DRAIN & pending & (MEM_IsLoad|MEM_IsStore)).
//   Zero-wait access: addr_ok in cycle N, data_ok in N+1 -> stall in N and N+1 is 0 only if data_ok.
//  advance = WB_Wr & ~MEM_MemStall. On advance, the WB register loads:
//   WB_Result = load ? ext(lane(data_rdata or DONE latch)) : MEM_ALUOut.
//   WB_Dst/WB_PC follow; WB_RegsWr = MEM_RegsWr & ~MEM_ExcValid & ~MEM_Flush.
//  WB_Flush: clears the WB register; it has priority over advance.
//  MEM_Flush while advancing: WB_RegsWr=0 is loaded (bubble).
//  Alignment, a=addr[1:0]:
//   byte: wstrb=1<<a; wdata={4{b}}; load lane rdata[8a+:8].
//   half: wstrb=3<<a (a[0]=0 guaranteed upstream); wdata={2{h}}; load lane rdata[8a+:16].
//   word: wstrb=4'hF.
//   Loads: wstrb=0.
//   Extension: to 32 bits per MEM_LoadSign.
//  perf_stall_cnt: +1 per stall cycle; holds at all-ones; reset only by rst.
//  Async rst mid-access: FSM->IDLE immediately, any outstanding bus response after reset is ignored by the bus owner (bus reset jointly).
// TESTING
//  LW addr 0x100, addr_ok cyc0, data_ok cyc2 rdata=0xDEADBEEF -> stall cyc0-1, WB_Result=0xDEADBEEF cyc3, perf_stall_cnt=2.
//  LB addr 0x103 sign, rdata=0x80112233 -> WB_Result=0xFFFFFF80. LHU addr 0x102, rdata=0x80112233 -> 0x00008011.
//  SB addr 0x201 data 0x000000AB -> data_wr=1, wstrb=4'b0010, wdata=0xABABABAB, WB_RegsWr=0.
//  Load completes with WB_Wr=0 for 3 cycles -> state DONE, data_req stays 0, latched data written when WB_Wr=1.
//  MEM_Flush in WAIT, data_ok 2 cycles later, next LW pending -> no req until cycle after drain data_ok, old data dropped.
//  MEM_ExcValid=1 with load -> data_req never 1, no stall, WB_RegsWr=0. Drive 2^STAT_W+5 stall cycles -> counter saturates 0xFFFF.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory access controller: issues the bus request in the cycle the op is seen, registers the result into WB on advance.
// Holds IF..MEM via MEM_MemStall until data_ok; a load finishing while WB is blocked parks its data in DONE.
module mem_access_ctrl #(
    parameter int STAT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              MEM_Flush,
    input  logic              WB_Wr,
    input  logic              WB_Flush,
    input  logic [31:0]       MEM_ALUOut,
    input  logic [31:0]       MEM_OutB,
    input  logic [31:0]       MEM_PC,
    input  logic [4:0]        MEM_Dst,
    input  logic              MEM_RegsWr,
    input  logic              MEM_IsLoad,
    input  logic              MEM_IsStore,
    input  logic [1:0]        MEM_Size,
    input  logic              MEM_LoadSign,
    input  logic              MEM_ExcValid,
    output logic              data_req,
    output logic              data_wr,
    output logic [1:0]        data_size,
    output logic [31:0]       data_addr,
    output logic [3:0]        data_wstrb,
    output logic [31:0]       data_wdata,
    input  logic              data_addr_ok,
    input  logic              data_data_ok,
    input  logic [31:0]       data_rdata,
    output logic              MEM_MemStall,
    output logic [31:0]       WB_Result,
    output logic [4:0]        WB_Dst,
    output logic              WB_RegsWr,
    output logic [31:0]       WB_PC,
    output logic [STAT_W-1:0] perf_stall_cnt
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_DONE  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        mem_op;
    logic        pending;
    logic        advance;
    logic        lat_en;
    logic [1:0]  addr_lo;
    logic [31:0] rdata_shift;
    logic [31:0] load_ext;
    logic [31:0] load_val;
    logic [31:0] lat_data;
    logic [3:0]  strb;
    logic [31:0] wdata;

    assign mem_op  = MEM_IsLoad | MEM_IsStore;
    assign pending = mem_op & ~MEM_ExcValid & ~MEM_Flush;
    assign advance = WB_Wr & ~MEM_MemStall;
    assign addr_lo = MEM_ALUOut[1:0];

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---------------- FSM: next state ----------------
    // Stall is low in WAIT-with-data_ok and in DONE, so advance reduces to WB_Wr there.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (pending && data_addr_ok) begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (data_data_ok) begin
                    state_nxt = (MEM_Flush || WB_Wr) ? S_IDLE : S_DONE;
                end else if (MEM_Flush) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DONE: begin
                if (WB_Wr || MEM_Flush) begin
                    state_nxt = S_IDLE;
                end
            end
            S_DRAIN: begin
                if (data_data_ok) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        data_req     = 1'b0;
        MEM_MemStall = 1'b0;
        lat_en       = 1'b0;
        case (state)
            S_IDLE: begin
                data_req     = pending;
                MEM_MemStall = pending;
            end
            S_WAIT: begin
                MEM_MemStall = ~data_data_ok;
                lat_en       = data_data_ok & ~MEM_Flush & ~WB_Wr;
            end
            S_DRAIN: begin
                MEM_MemStall = pending & mem_op;
            end
            default: begin
                data_req     = 1'b0;
                MEM_MemStall = 1'b0;
            end
        endcase
    end

    // ---------------- store lane placement ----------------
    always_comb begin
        strb  = 4'hF;
        wdata = MEM_OutB;
        case (MEM_Size)
            2'd0: begin
                strb  = 4'b0001 << addr_lo;
                wdata = {4{MEM_OutB[7:0]}};
            end
            2'd1: begin
                strb  = 4'b0011 << addr_lo;
                wdata = {2{MEM_OutB[15:0]}};
            end
            default: begin
                strb  = 4'hF;
                wdata = MEM_OutB;
            end
        endcase
    end

    assign data_wr    = MEM_IsStore;
    assign data_size  = MEM_Size;
    assign data_addr  = MEM_ALUOut;
    assign data_wstrb = MEM_IsStore ? strb : 4'h0;
    assign data_wdata = wdata;

    // ---------------- load lane select and extension ----------------
    always_comb begin
        rdata_shift = data_rdata >> {addr_lo, 3'b000};
        case (MEM_Size)
            2'd0: load_ext = MEM_LoadSign ? {{24{rdata_shift[7]}}, rdata_shift[7:0]}
                                          : {24'd0, rdata_shift[7:0]};
            2'd1: load_ext = MEM_LoadSign ? {{16{rdata_shift[15]}}, rdata_shift[15:0]}
                                          : {16'd0, rdata_shift[15:0]};
            default: load_ext = data_rdata;
        endcase
    end

    assign load_val = (state == S_DONE) ? lat_data : load_ext;

    // Holds the already-extended load result while WB is blocked.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat_data <= 32'd0;
        end else if (lat_en) begin
            lat_data <= load_ext;
        end
    end

    // ---------------- MEM->WB register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            WB_Result <= 32'd0;
            WB_Dst    <= 5'd0;
            WB_RegsWr <= 1'b0;
            WB_PC     <= 32'd0;
        end else if (WB_Flush) begin
            WB_Result <= 32'd0;
            WB_Dst    <= 5'd0;
            WB_RegsWr <= 1'b0;
            WB_PC     <= 32'd0;
        end else if (advance) begin
            WB_Result <= MEM_IsLoad ? load_val : MEM_ALUOut;
            WB_Dst    <= MEM_Dst;
            WB_RegsWr <= MEM_RegsWr & ~MEM_ExcValid & ~MEM_Flush;
            WB_PC     <= MEM_PC;
        end
    end

    // ---------------- stall-cycle counter ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_stall_cnt <= '0;
        end else if (MEM_MemStall && (perf_stall_cnt != {STAT_W{1'b1}})) begin
            perf_stall_cnt <= perf_stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: loads, stores, WB backpressure, flush/drain, exceptions, counter saturation, async reset.
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        MEM_Flush;
    logic        WB_Wr;
    logic        WB_Flush;
    logic [31:0] MEM_ALUOut;
    logic [31:0] MEM_OutB;
    logic [31:0] MEM_PC;
    logic [4:0]  MEM_Dst;
    logic        MEM_RegsWr;
    logic        MEM_IsLoad;
    logic        MEM_IsStore;
    logic [1:0]  MEM_Size;
    logic        MEM_LoadSign;
    logic        MEM_ExcValid;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;
    logic        MEM_MemStall;
    logic [31:0] WB_Result;
    logic [4:0]  WB_Dst;
    logic        WB_RegsWr;
    logic [31:0] WB_PC;
    logic [15:0] perf_stall_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    mem_access_ctrl #(.STAT_W(16)) dut (
        .clk            (clk),
        .rst            (rst),
        .MEM_Flush      (MEM_Flush),
        .WB_Wr          (WB_Wr),
        .WB_Flush       (WB_Flush),
        .MEM_ALUOut     (MEM_ALUOut),
        .MEM_OutB       (MEM_OutB),
        .MEM_PC         (MEM_PC),
        .MEM_Dst        (MEM_Dst),
        .MEM_RegsWr     (MEM_RegsWr),
        .MEM_IsLoad     (MEM_IsLoad),
        .MEM_IsStore    (MEM_IsStore),
        .MEM_Size       (MEM_Size),
        .MEM_LoadSign   (MEM_LoadSign),
        .MEM_ExcValid   (MEM_ExcValid),
        .data_req       (data_req),
        .data_wr        (data_wr),
        .data_size      (data_size),
        .data_addr      (data_addr),
        .data_wstrb     (data_wstrb),
        .data_wdata     (data_wdata),
        .data_addr_ok   (data_addr_ok),
        .data_data_ok   (data_data_ok),
        .data_rdata     (data_rdata),
        .MEM_MemStall   (MEM_MemStall),
        .WB_Result      (WB_Result),
        .WB_Dst         (WB_Dst),
        .WB_RegsWr      (WB_RegsWr),
        .WB_PC          (WB_PC),
        .perf_stall_cnt (perf_stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in;
        MEM_Flush    = 1'b0;
        WB_Wr        = 1'b1;
        WB_Flush     = 1'b0;
        MEM_ALUOut   = 32'd0;
        MEM_OutB     = 32'd0;
        MEM_PC       = 32'd0;
        MEM_Dst      = 5'd0;
        MEM_RegsWr   = 1'b0;
        MEM_IsLoad   = 1'b0;
        MEM_IsStore  = 1'b0;
        MEM_Size     = 2'd0;
        MEM_LoadSign = 1'b0;
        MEM_ExcValid = 1'b0;
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        data_rdata   = 32'd0;
    endtask

    // Zero-wait load: addr_ok in the first cycle, data_ok in the next.
    task automatic do_load(input string tag, input logic [31:0] addr, input logic [1:0] size,
                           input logic sgn, input logic [31:0] rdata, input logic [31:0] exp);
        MEM_IsLoad   = 1'b1;
        MEM_ALUOut   = addr;
        MEM_Size     = size;
        MEM_LoadSign = sgn;
        MEM_RegsWr   = 1'b1;
        MEM_Dst      = 5'd7;
        data_addr_ok = 1'b1;
        #1 chk({tag, "_req"}, 32'(data_req), 32'd1);
        tick;
        data_addr_ok = 1'b0;
        data_data_ok = 1'b1;
        data_rdata   = rdata;
        #1 chk({tag, "_stall"}, 32'(MEM_MemStall), 32'd0);
        tick;
        idle_in;
        #1 chk(tag, WB_Result, exp);
    endtask

    task automatic do_store(input string tag, input logic [31:0] addr, input logic [1:0] size,
                            input logic [31:0] wd, input logic [3:0] exp_strb, input logic [31:0] exp_wd);
        MEM_IsStore  = 1'b1;
        MEM_ALUOut   = addr;
        MEM_Size     = size;
        MEM_OutB     = wd;
        data_addr_ok = 1'b1;
        #1;
        chk({tag, "_wr"}, 32'(data_wr), 32'd1);
        chk({tag, "_strb"}, 32'(data_wstrb), 32'(exp_strb));
        chk({tag, "_wdata"}, data_wdata, exp_wd);
        tick;
        data_addr_ok = 1'b0;
        data_data_ok = 1'b1;
        tick;
        idle_in;
        #1;
        chk({tag, "_regswr"}, 32'(WB_RegsWr), 32'd0);
        chk({tag, "_res"}, WB_Result, addr);
    endtask

    initial begin
        rst = 1'b1;
        idle_in;
        #2;
        chk("rst_req", 32'(data_req), 32'd0);
        chk("rst_stall", 32'(MEM_MemStall), 32'd0);
        chk("rst_wbres", WB_Result, 32'd0);
        chk("rst_wbregswr", 32'(WB_RegsWr), 32'd0);
        chk("rst_perf", 32'(perf_stall_cnt), 32'd0);
        tick;
        tick;
        rst = 1'b0;
        tick;

        // LW 0x100: addr_ok cyc0, data_ok cyc2
        MEM_IsLoad = 1'b1; MEM_Size = 2'd2; MEM_ALUOut = 32'h100; MEM_RegsWr = 1'b1;
        MEM_Dst = 5'd5; MEM_PC = 32'h400; data_addr_ok = 1'b1;
        #1;
        chk("lw_req", 32'(data_req), 32'd1);
        chk("lw_stall0", 32'(MEM_MemStall), 32'd1);
        chk("lw_addr", data_addr, 32'h100);
        chk("lw_strb", 32'(data_wstrb), 32'd0);
        tick;
        data_addr_ok = 1'b0;
        #1;
        chk("lw_stall1", 32'(MEM_MemStall), 32'd1);
        chk("lw_req1", 32'(data_req), 32'd0);
        tick;
        data_data_ok = 1'b1; data_rdata = 32'hDEADBEEF;
        #1 chk("lw_stall2", 32'(MEM_MemStall), 32'd0);
        tick;
        idle_in;
        #1;
        chk("lw_res", WB_Result, 32'hDEADBEEF);
        chk("lw_regswr", 32'(WB_RegsWr), 32'd1);
        chk("lw_dst", 32'(WB_Dst), 32'd5);
        chk("lw_pc", WB_PC, 32'h400);
        chk("lw_perf", 32'(perf_stall_cnt), 32'd2);

        // load alignment / extension
        do_load("lb_s",  32'h103, 2'd0, 1'b1, 32'h80112233, 32'hFFFFFF80);
        do_load("lhu",   32'h102, 2'd1, 1'b0, 32'h80112233, 32'h00008011);
        do_load("lbu",   32'h101, 2'd0, 1'b0, 32'h80112233, 32'h00000022);
        do_load("lh_s",  32'h100, 2'd1, 1'b1, 32'h1234F00D, 32'hFFFFF00D);
        do_load("lsz3",  32'h104, 2'd3, 1'b1, 32'hCAFEF00D, 32'hCAFEF00D);
        chk("perf_loads", 32'(perf_stall_cnt), 32'd7);

        // stores
        do_store("sb", 32'h201, 2'd0, 32'h000000AB, 4'b0010, 32'hABABABAB);
        do_store("sh", 32'h202, 2'd1, 32'h00001234, 4'b1100, 32'h12341234);
        do_store("sw", 32'h208, 2'd2, 32'h89ABCDEF, 4'b1111, 32'h89ABCDEF);

        // load completes while WB blocked for 3 cycles
        MEM_IsLoad = 1'b1; MEM_Size = 2'd2; MEM_ALUOut = 32'h300; MEM_RegsWr = 1'b1; data_addr_ok = 1'b1;
        tick;
        data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h12345678; WB_Wr = 1'b0;
        #1 chk("done_stall", 32'(MEM_MemStall), 32'd0);
        tick;
        data_data_ok = 1'b0; data_rdata = 32'hFFFFFFFF; data_addr_ok = 1'b1;
        #1;
        chk("done_req0", 32'(data_req), 32'd0);
        chk("done_stall0", 32'(MEM_MemStall), 32'd0);
        tick;
        #1;
        chk("done_req1", 32'(data_req), 32'd0);
        chk("done_hold", WB_Result, 32'h208);
        tick;
        WB_Wr = 1'b1;
        #1 chk("done_req2", 32'(data_req), 32'd0);
        tick;
        idle_in;
        #1;
        chk("done_res", WB_Result, 32'h12345678);
        chk("done_regswr", 32'(WB_RegsWr), 32'd1);

        // flush in WAIT, drain, then next LW
        MEM_IsLoad = 1'b1; MEM_Size = 2'd2; MEM_ALUOut = 32'h400; MEM_RegsWr = 1'b1; data_addr_ok = 1'b1;
        tick;
        data_addr_ok = 1'b0; MEM_Flush = 1'b1;
        #1 chk("fl_stall", 32'(MEM_MemStall), 32'd1);
        tick;
        MEM_Flush = 1'b0; MEM_ALUOut = 32'h500; MEM_PC = 32'h900; data_addr_ok = 1'b1;
        #1;
        chk("drain_req0", 32'(data_req), 32'd0);
        chk("drain_stall0", 32'(MEM_MemStall), 32'd1);
        tick;
        data_data_ok = 1'b1; data_rdata = 32'hBAD0BAD0;
        #1;
        chk("drain_req1", 32'(data_req), 32'd0);
        chk("drain_stall1", 32'(MEM_MemStall), 32'd1);
        tick;
        data_data_ok = 1'b0;
        #1 chk("drain_newreq", 32'(data_req), 32'd1);
        tick;
        data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h600D600D;
        tick;
        idle_in;
        #1;
        chk("drain_res", WB_Result, 32'h600D600D);
        chk("drain_pc", WB_PC, 32'h900);

        // exception-flagged load
        MEM_IsLoad = 1'b1; MEM_Size = 2'd2; MEM_ExcValid = 1'b1; MEM_RegsWr = 1'b1; data_addr_ok = 1'b1;
        #1;
        chk("exc_req", 32'(data_req), 32'd0);
        chk("exc_stall", 32'(MEM_MemStall), 32'd0);
        tick;
        idle_in;
        #1 chk("exc_regswr", 32'(WB_RegsWr), 32'd0);

        // plain ALU op, flushed ALU op, WB_Flush priority
        MEM_RegsWr = 1'b1; MEM_ALUOut = 32'h77; MEM_Dst = 5'd3;
        tick;
        #1;
        chk("alu_res", WB_Result, 32'h77);
        chk("alu_regswr", 32'(WB_RegsWr), 32'd1);
        MEM_Flush = 1'b1; MEM_ALUOut = 32'h99;
        tick;
        #1;
        chk("mflush_res", WB_Result, 32'h99);
        chk("mflush_regswr", 32'(WB_RegsWr), 32'd0);
        MEM_Flush = 1'b0; WB_Flush = 1'b1; MEM_ALUOut = 32'h55;
        tick;
        #1;
        chk("wbflush_res", WB_Result, 32'd0);
        chk("wbflush_dst", 32'(WB_Dst), 32'd0);
        idle_in;

        // counter saturation: hold a pending load without addr_ok
        MEM_IsLoad = 1'b1; MEM_Size = 2'd2; MEM_ALUOut = 32'h700;
        for (int i = 0; i < 65541; i++) begin
            @(posedge clk);
        end
        #1;
        chk("sat_perf", 32'(perf_stall_cnt), 32'h0000FFFF);
        chk("sat_req_held", 32'(data_req), 32'd1);
        tick;
        chk("sat_perf_hold", 32'(perf_stall_cnt), 32'h0000FFFF);

        // async reset mid-access
        data_addr_ok = 1'b1;
        tick;
        data_addr_ok = 1'b0;
        #1 chk("ar_wait_req", 32'(data_req), 32'd0);
        #1 rst = 1'b1;
        #1;
        chk("ar_idle_req", 32'(data_req), 32'd1);
        chk("ar_perf", 32'(perf_stall_cnt), 32'd0);
        chk("ar_wbres", WB_Result, 32'd0);
        tick;
        rst = 1'b0;
        idle_in;
        tick;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
